// File: rtl/mul_sequencer_if.sv
// Instruction/result bundle between the ID/EX stage and the sequential multiplier.
// valid_i qualifies the instruction fields; stall_o acts as the not-ready back-pressure and done_o marks result_o valid.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [1:0]       ALUOp_i;
  logic [9:0]       funct_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             stall_o;
  logic             done_o;
  logic             busy_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output valid_i, flush_i, ALUOp_i, funct_i, rs1_data_i, rs2_data_i,
    input  stall_o, done_o, busy_o, result_o
  );

  modport slave (
    input  valid_i, flush_i, ALUOp_i, funct_i, rs1_data_i, rs2_data_i,
    output stall_o, done_o, busy_o, result_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier: one multiplier bit per cycle, WIDTH RUN cycles, low WIDTH result bits.
// state_o exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_sequencer_if.slave bus,
  output logic [1:0]    state_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_sum, result_q;
  logic [CW-1:0]    count;
  logic             is_mul, accept, last_step;

  assign is_mul    = (bus.ALUOp_i == 2'b11) && (bus.funct_i[9:3] == 7'b0000001) &&
                     (bus.funct_i[2:0] == 3'b000);
  assign accept    = (state == IDLE) && bus.valid_i && is_mul && !bus.flush_i;
  assign last_step = (count == LAST);
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.flush_i)    state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is gated by reset so a MUL presented during reset cannot hold the pipeline.
  always_comb begin
    bus.stall_o = rst_i && ((state == RUN) || accept);
    bus.busy_o  = (state == RUN);
    bus.done_o  = (state == DONE);
    state_o     = state;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
    end else if (accept) begin
      mcand  <= bus.rs1_data_i;
      mplier <= bus.rs2_data_i;
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      if (bus.flush_i) begin
        acc <= '0;
      end else begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        // Hold count at LAST rather than wrapping as the operation completes.
        if (!last_step) count <= count + 1'b1;
        else            result_q <= acc_sum;
      end
    end
  end

  assign bus.result_o = result_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed scenarios plus random products,
// results checked against a queue of expected products on every done_o pulse.
module tb_mul_sequencer;
  localparam int W = 32;
  localparam logic [9:0] MUL_FUNCT = 10'b0000001_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] last_result = '0;
  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: every done_o pulse consumes one expected product.
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: result_o=%h with no expected entry", bus.result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.result_o !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_result: result_o=%h expected=%h", bus.result_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.valid_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.ALUOp_i    = 2'b00;
    bus.funct_i    = 10'd0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
  endtask

  task automatic drive_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.ALUOp_i    = 2'b11;
    bus.funct_i    = MUL_FUNCT;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
  endtask

  // Issues one MUL, scrambles inputs during RUN, returns at the negedge where done_o is seen.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int stalls, output int busys);
    logic [W-1:0] p;
    @(negedge clk);
    drive_mul(a, b);
    p = a * b;
    exp_q.push_back(p);
    #1;
    stalls = bus.stall_o ? 1 : 0;
    busys  = 0;
    lat    = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.busy_o)  busys++;
      if (bus.done_o)  lat = k;
      bus.valid_i    = (k < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_mul(32'd5, 32'd7);
    #2;
    n_checks += 5;
    if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    if (bus.result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    repeat (2) @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    last_result = '0;
  endtask

  task automatic test_basic();
    int lat, stalls, busys;
    run_mul(32'd7, 32'd6, lat, stalls, busys);
    n_checks += 4;
    if (lat !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
    if (stalls !== 33) begin n_fail++; $display("FAIL basic_stall_cycles: got %0d want 33", stalls); end
    if (busys !== 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 32", busys); end
    if (bus.result_o !== 32'd42) begin n_fail++; $display("FAIL basic_result: got %0d want 42", bus.result_o); end
    @(negedge clk);
    n_checks += 2;
    if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", bus.done_o); end
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL basic_back_idle: got %0d want 0", state_dbg); end
    last_result = 32'd42;
  endtask

  task automatic test_ignored();
    logic [1:0] ops[4]   = '{2'b11, 2'b11, 2'b10, 2'b11};
    logic [9:0] functs[4] = '{10'd0, 10'b0000001_001, MUL_FUNCT, 10'b0100000_000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.valid_i    = 1'b1;
      bus.ALUOp_i    = ops[i];
      bus.funct_i    = functs[i];
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      #1;
      n_checks++;
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL ignored_stall[%0d]: got %b want 0", i, bus.stall_o); end
      @(negedge clk);
      n_checks += 4;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL ignored_busy[%0d]: got %b want 0", i, bus.busy_o); end
      if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL ignored_done[%0d]: got %b want 0", i, bus.done_o); end
      if (bus.result_o !== last_result) begin n_fail++; $display("FAIL ignored_result[%0d]: got %h want %h", i, bus.result_o, last_result); end
      if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL ignored_state[%0d]: got %0d want 0", i, state_dbg); end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int dones, lat, stalls, busys;
    @(negedge clk);
    drive_mul(32'd3, 32'd5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    n_checks++;
    if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", bus.busy_o); end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    n_checks += 2;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy_o); end
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL flush_state: got %0d want 0", state_dbg); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    n_checks += 2;
    if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    if (bus.result_o !== last_result) begin n_fail++; $display("FAIL flush_result_kept: got %h want %h", bus.result_o, last_result); end
    // Flush alongside a valid MUL in IDLE must block acceptance.
    @(negedge clk);
    drive_mul(32'd8, 32'd8);
    bus.flush_i = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall_o); end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy_o); end
    // Flush during DONE must leave that done_o pulse intact.
    run_mul(32'd11, 32'd13, lat, stalls, busys);
    bus.flush_i = 1'b1;
    #1;
    n_checks += 2;
    if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL flush_done_kept: got %b want 1", bus.done_o); end
    if (bus.result_o !== 32'd143) begin n_fail++; $display("FAIL flush_done_result: got %0d want 143", bus.result_o); end
    @(negedge clk);
    bus.flush_i = 1'b0;
    last_result = 32'd143;
  endtask

  task automatic test_wrap();
    int lat, stalls, busys;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, busys);
    n_checks += 2;
    if (bus.result_o !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_ones: got %h want 00000001", bus.result_o); end
    if (lat !== 33) begin n_fail++; $display("FAIL wrap_ones_latency: got %0d want 33", lat); end
    run_mul(32'h8000_0000, 32'd2, lat, stalls, busys);
    n_checks++;
    if (bus.result_o !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_msb: got %h want 00000000", bus.result_o); end
    run_mul(32'd0, 32'h1234, lat, stalls, busys);
    n_checks += 2;
    if (lat !== 33) begin n_fail++; $display("FAIL zero_latency: got %0d want 33", lat); end
    if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL zero_result: got %h want 0", bus.result_o); end
    last_result = 32'd0;
  endtask

  task automatic test_reset_mid();
    int lat, stalls, busys, dones;
    logic [W-1:0] p;
    run_mul(32'd100, 32'd3, lat, stalls, busys);
    @(negedge clk);
    drive_mul(32'd3, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b want 0", bus.stall_o); end
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy_o); end
    if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.done_o); end
    if (bus.result_o !== '0) begin n_fail++; $display("FAIL midrst_result: got %h want 0", bus.result_o); end
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", state_dbg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_not_resumed: got %0d pulses want 0", dones); end
    run_mul(32'd9, 32'd9, lat, stalls, busys);
    p = 32'd81;
    n_checks += 3;
    if (lat !== 33) begin n_fail++; $display("FAIL postrst_latency: got %0d want 33", lat); end
    if (stalls !== 33) begin n_fail++; $display("FAIL postrst_stall_cycles: got %0d want 33", stalls); end
    if (bus.result_o !== p) begin n_fail++; $display("FAIL postrst_result: got %0d want 81", bus.result_o); end
    last_result = p;
  endtask

  task automatic test_back_to_back();
    int lat, stalls, busys, d1, d2;
    run_mul(32'd2, 32'd3, lat, stalls, busys);
    d1 = cyc;
    n_checks++;
    if (bus.result_o !== 32'd6) begin n_fail++; $display("FAIL b2b_first: got %0d want 6", bus.result_o); end
    run_mul(32'd4, 32'd5, lat, stalls, busys);
    d2 = cyc;
    n_checks += 2;
    if (bus.result_o !== 32'd20) begin n_fail++; $display("FAIL b2b_second: got %0d want 20", bus.result_o); end
    if (d2 - d1 !== 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 34", d2 - d1); end
    last_result = 32'd20;
  endtask

  task automatic test_random();
    int lat, stalls, busys;
    logic [W-1:0] a, b, p;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_mul(a, b, lat, stalls, busys);
      p = a * b;
      n_checks += 2;
      if (lat !== 33) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 33", i, lat); end
      if (bus.result_o !== p) begin n_fail++; $display("FAIL rand_result[%0d]: got %h want %h", i, bus.result_o, p); end
      last_result = p;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_ignored();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_drain: %0d entries left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
